// File: rtl/sp_double_mac_feeder.sv
// Operand feeder for the dual int4 x int8 MAC row: buffers operand quadruples in a FIFO,
// issues them with a precomputed 9-bit mix term, and sequences accumulator clear / tile done.
module sp_double_mac_feeder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             busy,
    output logic             done,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [3:0]       s_a1,
    input  logic [3:0]       s_a2,
    input  logic [7:0]       s_b1,
    input  logic [7:0]       s_b2,
    input  logic             m_hold,
    output logic             m_pulse,
    output logic [3:0]       m_a1,
    output logic [3:0]       m_a2,
    output logic [7:0]       m_b1,
    output logic [7:0]       m_b2,
    output logic [8:0]       m_mix,
    output logic             m_acc_clr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [23:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_pulse;
    logic [3:0]       r_a1;
    logic [3:0]       r_a2;
    logic [7:0]       r_b1;
    logic [7:0]       r_b2;
    logic [8:0]       r_mix;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_last_pop;
    logic [23:0] w_rd;
    logic [8:0]  w_mix;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = s_valid && !w_full;
    assign w_pop      = (r_state == ST_RUN) && !w_empty && !m_hold && (r_cnt < r_len);
    assign w_last_pop = w_pop && ((r_cnt + LEN_W'(1)) == r_len);
    assign w_rd       = r_mem[r_rptr];
    // Zero-extend both activations so the sum never truncates.
    assign w_mix      = {1'b0, w_rd[15:8]} + {1'b0, w_rd[7:0]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {s_a1, s_a2, s_b1, s_b2};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = (r_len == '0) ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (w_last_pop) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_a1    <= '0;
            r_a2    <= '0;
            r_b1    <= '0;
            r_b2    <= '0;
            r_mix   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_cnt  <= r_cnt + LEN_W'(1);
                r_a1   <= w_rd[23:20];
                r_a2   <= w_rd[19:16];
                r_b1   <= w_rd[15:8];
                r_b2   <= w_rd[7:0];
                r_mix  <= w_mix;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if ((r_state == ST_IDLE) && start) begin
                r_len <= cfg_len;
                r_cnt <= '0;
            end
        end
    end

    assign s_ready   = !w_full;
    assign busy      = (r_state == ST_CLEAR) || (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign done      = (r_state == ST_DONE);
    assign m_acc_clr = (r_state == ST_CLEAR);
    assign m_pulse   = r_pulse;
    assign m_a1      = r_a1;
    assign m_a2      = r_a2;
    assign m_b1      = r_b1;
    assign m_b2      = r_b2;
    assign m_mix     = r_mix;

endmodule

// File: tb/tb_sp_double_mac_feeder.sv
// Scoreboard bench for sp_double_mac_feeder: accepted pushes feed an in-order model queue,
// and a negedge monitor checks every pulse and every done against it.
module tb_sp_double_mac_feeder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             busy;
    logic             done;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [3:0]       s_a1 = '0;
    logic [3:0]       s_a2 = '0;
    logic [7:0]       s_b1 = '0;
    logic [7:0]       s_b2 = '0;
    logic             m_hold = 1'b0;
    logic             m_pulse;
    logic [3:0]       m_a1;
    logic [3:0]       m_a2;
    logic [7:0]       m_b1;
    logic [7:0]       m_b2;
    logic [8:0]       m_mix;
    logic             m_acc_clr;

    sp_double_mac_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .done     (done),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_a1     (s_a1),
        .s_a2     (s_a2),
        .s_b1     (s_b1),
        .s_b2     (s_b2),
        .m_hold   (m_hold),
        .m_pulse  (m_pulse),
        .m_a1     (m_a1),
        .m_a2     (m_a2),
        .m_b1     (m_b1),
        .m_b2     (m_b2),
        .m_mix    (m_mix),
        .m_acc_clr(m_acc_clr)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [23:0] model_q[$];
    int          pulse_cyc_q[$];
    int          pulses_in_tile = 0;
    int          cur_len = 0;
    int          last_pulse_cyc = 0;
    logic        prev_hold = 1'b0;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        prev_hold <= m_hold;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must deliver the oldest outstanding quadruple.
    always @(negedge clk) begin
        logic [23:0] e;
        if (!reset) begin
            if (prev_hold) check("pulse_after_hold", {31'd0, m_pulse}, 32'd0);
            if (m_pulse) begin
                if (model_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL pulse_unexpected: got a pulse, expected none (cycle %0d)", cyc);
                end else begin
                    e = model_q.pop_front();
                    check("m_a1", {28'd0, m_a1}, {28'd0, e[23:20]});
                    check("m_a2", {28'd0, m_a2}, {28'd0, e[19:16]});
                    check("m_b1", {24'd0, m_b1}, {24'd0, e[15:8]});
                    check("m_b2", {24'd0, m_b2}, {24'd0, e[7:0]});
                    check("m_mix", {23'd0, m_mix}, int'(e[15:8]) + int'(e[7:0]));
                end
                pulses_in_tile++;
                last_pulse_cyc = cyc;
                pulse_cyc_q.push_back(cyc);
            end
            if (done) begin
                check("tile_pulses", pulses_in_tile, cur_len);
                if (cur_len > 0) check("done_after_pulse", cyc - last_pulse_cyc, 1);
            end
        end
    end

    task automatic push(input logic [23:0] d, output int stall);
        stall   = 0;
        s_valid = 1'b1;
        {s_a1, s_a2, s_b1, s_b2} = d;
        while (!s_ready && stall < 300) begin
            @(negedge clk);
            stall++;
        end
        if (s_ready) begin
            model_q.push_back(d);
            @(negedge clk);
        end else begin
            n_vec++;
            n_fail++;
            $display("FAIL push_timeout: s_ready stayed 0, required 1");
        end
        s_valid = 1'b0;
    endtask

    task automatic push_rand(input int n);
        int st;
        for (int i = 0; i < n; i++) begin
            logic [23:0] d;
            d = 24'($urandom());
            push(d, st);
        end
    endtask

    // Returns in cycle t+1, where t is the cycle that samples start.
    task automatic start_tile(input int len);
        pulses_in_tile = 0;
        cur_len        = len;
        pulse_cyc_q.delete();
        start   = 1'b1;
        cfg_len = LEN_W'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns in the IDLE cycle after done.
    task automatic wait_done(input bit rnd);
        int k;
        k = 0;
        while (!done && k < 600) begin
            if (rnd) m_hold = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            k++;
        end
        m_hold = 1'b0;
        if (!done) begin
            n_vec++;
            n_fail++;
            $display("FAIL done_timeout: done stayed 0, required 1");
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int st5;
        int np;
        int k;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_pulse", {31'd0, m_pulse}, 0);
        check("rst_acc_clr", {31'd0, m_acc_clr}, 0);
        check("rst_mix", {23'd0, m_mix}, 0);
        check("rst_ab", {8'd0, m_a1, m_a2, m_b1, m_b2}, 0);
        check("rst_ready", {31'd0, s_ready}, 1);

        // Single quadruple with exact cycle positions.
        push(24'h3E0AF0, st);
        start_tile(1);
        check("t1_acc_clr", {31'd0, m_acc_clr}, 1);
        check("t1_busy", {31'd0, busy}, 1);
        @(negedge clk);
        check("t2_acc_clr", {31'd0, m_acc_clr}, 0);
        check("t2_pulse", {31'd0, m_pulse}, 0);
        @(negedge clk);
        check("t3_pulse", {31'd0, m_pulse}, 1);
        check("t3_mix", {23'd0, m_mix}, 32'h0FA);
        check("t3_a", {24'd0, m_a1, m_a2}, 32'h3E);
        @(negedge clk);
        check("t4_done", {31'd0, done}, 1);
        check("t4_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("t5_done", {31'd0, done}, 0);

        // Mix overflow.
        push(24'h12FFFF, st);
        push(24'h788080, st);
        start_tile(2);
        repeat (2) @(negedge clk);
        check("mix_1fe", {23'd0, m_mix}, 32'h1FE);
        @(negedge clk);
        check("mix_100", {23'd0, m_mix}, 32'h100);
        @(negedge clk);
        check("mix_done", {31'd0, done}, 1);
        @(negedge clk);
        check("mix_hold", {23'd0, m_mix}, 32'h100);
        check("mix_no_pulse", {31'd0, m_pulse}, 0);

        // FIFO full and pointer wrap.
        push_rand(4);
        check("full_ready", {31'd0, s_ready}, 0);
        fork
            begin
                logic [23:0] d;
                d = 24'($urandom());
                push(d, st5);
                d = 24'($urandom());
                push(d, st);
            end
            begin
                start_tile(6);
                wait_done(0);
            end
        join
        check("stall5", {31'd0, st5 != 0}, 1);
        check("full_done_once", {31'd0, done}, 0);

        // Backpressure: two hold cycles mid-run.
        push_rand(3);
        start_tile(3);
        @(negedge clk);
        @(negedge clk);
        m_hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_hold = 1'b0;
        wait_done(0);
        check("bp_pulses", pulse_cyc_q.size(), 3);
        if (pulse_cyc_q.size() == 3) check("bp_span", pulse_cyc_q[2] - pulse_cyc_q[0], 4);

        // Zero length leaves queued entries alone; start during RUN is ignored.
        push_rand(2);
        start_tile(0);
        check("z_acc_clr", {31'd0, m_acc_clr}, 1);
        @(negedge clk);
        check("z_flush_clr", {31'd0, m_acc_clr}, 0);
        check("z_flush_busy", {31'd0, busy}, 1);
        @(negedge clk);
        check("z_done", {31'd0, done}, 1);
        @(negedge clk);
        check("z_idle", {31'd0, busy}, 0);
        m_hold = 1'b1;
        start_tile(2);
        @(negedge clk);
        start   = 1'b1;
        cfg_len = LEN_W'(7);
        @(negedge clk);
        start  = 1'b0;
        m_hold = 1'b0;
        wait_done(0);
        for (int i = 0; i < 3; i++) begin
            check("ign_busy", {31'd0, busy}, 0);
            check("ign_clr", {31'd0, m_acc_clr}, 0);
            @(negedge clk);
        end

        // Reset after the second of five pulses.
        push_rand(4);
        start_tile(5);
        np = 0;
        k  = 0;
        while (np < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (m_pulse) np++;
        end
        check("rst_mid_pulses", np, 2);
        reset = 1'b1;
        @(negedge clk);
        check("rm_busy", {31'd0, busy}, 0);
        check("rm_pulse", {31'd0, m_pulse}, 0);
        check("rm_clr", {31'd0, m_acc_clr}, 0);
        check("rm_mix", {23'd0, m_mix}, 0);
        check("rm_ab", {8'd0, m_a1, m_a2, m_b1, m_b2}, 0);
        check("rm_ready", {31'd0, s_ready}, 1);
        model_q.delete();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rm_no_done", {31'd0, done}, 0);
        end
        push_rand(2);
        start_tile(2);
        wait_done(0);

        // Randomized tiles with random backpressure and concurrent pushes.
        for (int t = 0; t < 10; t++) begin
            int len;
            len = $urandom_range(1, 9);
            fork
                push_rand(len);
                begin
                    start_tile(len);
                    wait_done(1);
                end
            join
        end

        check("model_drained", model_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
